// File: rtl/pipe_mux_tree.sv
// pipe_mux_tree: N-to-1 selector built as a binary tree of 2:1 stages.
// Level k picks between adjacent survivors of level k-1 using Sel[k]; the
// valid flag and the still-unused select bits travel with the data.
//
// Build option PIPE_MUX_TREE_STAGE_REG_EN:
//   defined   -> a register stage after every tree level (latency = log2(N))
//   undefined -> combinational tree plus one output register (latency = 1)
// In both builds rst (sync, active-high) beats En, and En=0 freezes every
// register including Y and Out_Valid.
module pipe_mux_tree #(
    parameter int WIDTH      = 32,
    parameter int NUM_INPUTS = 8,
    localparam int SEL_W     = $clog2(NUM_INPUTS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        En,
    input  logic                        In_Valid,
    input  logic [WIDTH*NUM_INPUTS-1:0] I,
    input  logic [SEL_W-1:0]            Sel,
    output logic [WIDTH-1:0]            Y,
    output logic                        Out_Valid
);

    // Select bits are kept right-aligned: each level consumes bit 0 and hands
    // the remainder (shifted down by one) to the next level, so every level
    // always sees the select of the request it is currently holding.
    for (genvar k = 0; k < SEL_W; k++) begin : g_lvl
        localparam int NOUT = NUM_INPUTS >> (k + 1);

        logic [2*NOUT*WIDTH-1:0] cand;
        logic [SEL_W-1:0]        sel_in;
        logic                    vld_in;

        logic [NOUT*WIDTH-1:0]   data_d;
        logic [SEL_W-1:0]        sel_d;
        logic                    vld_d;

        logic [NOUT*WIDTH-1:0]   data_o;
        logic [SEL_W-1:0]        sel_o;
        logic                    vld_o;

        if (k == 0) begin : g_src
            assign cand   = I;
            assign sel_in = Sel;
            assign vld_in = In_Valid;
        end else begin : g_src
            assign cand   = g_lvl[k-1].data_o;
            assign sel_in = g_lvl[k-1].sel_o;
            assign vld_in = g_lvl[k-1].vld_o;
        end

        // Pairwise 2:1 selection of adjacent candidates by this level's select bit.
        always_comb begin
            data_d = '0;
            for (int j = 0; j < NOUT; j++) begin
                data_d[j*WIDTH +: WIDTH] = sel_in[0] ? cand[(2*j+1)*WIDTH +: WIDTH]
                                                     : cand[(2*j)*WIDTH +: WIDTH];
            end
        end

        assign sel_d = sel_in >> 1;
        assign vld_d = vld_in;

`ifdef PIPE_MUX_TREE_STAGE_REG_EN
        logic [NOUT*WIDTH-1:0] data_q;
        logic [SEL_W-1:0]      sel_q;
        logic                  vld_q;

        // Level register: data, remaining select bits and valid advance together.
        always_ff @(posedge clk) begin
            if (rst) begin
                data_q <= '0;
                sel_q  <= '0;
                vld_q  <= 1'b0;
            end else if (En) begin
                data_q <= data_d;
                sel_q  <= sel_d;
                vld_q  <= vld_d;
            end
        end

        assign data_o = data_q;
        assign sel_o  = sel_q;
        assign vld_o  = vld_q;
`else
        assign data_o = data_d;
        assign sel_o  = sel_d;
        assign vld_o  = vld_d;
`endif
    end

    // The last level has no consumer for its leftover select bits.
    logic unused_sel_tail;
    assign unused_sel_tail = ^g_lvl[SEL_W-1].sel_o;

`ifdef PIPE_MUX_TREE_STAGE_REG_EN
    // The final level register is the output register.
    assign Y         = g_lvl[SEL_W-1].data_o;
    assign Out_Valid = g_lvl[SEL_W-1].vld_o;
`else
    logic [WIDTH-1:0] y_d;
    logic [WIDTH-1:0] y_q;
    logic             out_valid_d;
    logic             out_valid_q;

    assign y_d         = g_lvl[SEL_W-1].data_o;
    assign out_valid_d = g_lvl[SEL_W-1].vld_o;

    // Single output register after the combinational tree.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q         <= '0;
            out_valid_q <= 1'b0;
        end else if (En) begin
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign Y         = y_q;
    assign Out_Valid = out_valid_q;
`endif

endmodule

// File: tb/tb_pipe_mux_tree.sv
// tb_pipe_mux_tree: directed bench for pipe_mux_tree with N=8, W=32.
// Expected latency follows the PIPE_MUX_TREE_STAGE_REG_EN build option.
module tb_pipe_mux_tree;

    localparam int W = 32;
    localparam int N = 8;
`ifdef PIPE_MUX_TREE_STAGE_REG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           En;
    logic           In_Valid;
    logic [W*N-1:0] I_s;
    logic [2:0]     Sel;
    logic [W-1:0]   Y;
    logic           Out_Valid;

    int n_cmp = 0;
    int n_bad = 0;

    pipe_mux_tree #(.WIDTH(W), .NUM_INPUTS(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .En        (En),
        .In_Valid  (In_Valid),
        .I         (I_s),
        .Sel       (Sel),
        .Y         (Y),
        .Out_Valid (Out_Valid)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ramp_inputs();
        for (int k = 0; k < N; k++) I_s[k*W +: W] = 32'hA000_0000 + k;
    endtask

    // Stream Sel = 0..7 with En=1, optionally with an En=0 window of stall_len
    // cycles starting at cycle stall_at. During the stall junk is presented and
    // must be ignored. After each edge, with acc En-edges so far, the output
    // must carry request (acc - LAT) if that index exists, else be invalid.
    task automatic run_stream(input int stall_at, input int stall_len, input string name);
        int acc;
        int idx;
        acc = 0;
        for (int t = 0; t < N + LAT + stall_len + 2; t++) begin
            if (t >= stall_at && t < stall_at + stall_len) begin
                En       = 1'b0;
                In_Valid = 1'b1;
                Sel      = 3'd7;
                I_s      = '1;
            end else begin
                En = 1'b1;
                ramp_inputs();
                if (acc < N) begin
                    In_Valid = 1'b1;
                    Sel      = acc[2:0];
                end else begin
                    In_Valid = 1'b0;
                    Sel      = 3'd0;
                end
                acc++;
            end
            step();
            idx = acc - LAT;
            if (idx >= 0 && idx < N) begin
                check_eq($sformatf("%s_vld_t%0d", name, t), {31'd0, Out_Valid}, 32'd1);
                check_eq($sformatf("%s_y_t%0d", name, t), Y, 32'hA000_0000 + idx);
            end else begin
                check_eq($sformatf("%s_vld_t%0d", name, t), {31'd0, Out_Valid}, 32'd0);
            end
        end
    endtask

    initial begin
        int r;
        rst      = 1'b1;
        En       = 1'b1;
        In_Valid = 1'b1;
        Sel      = 3'd0;
        I_s      = '0;

        // Reset held two cycles with live, valid-looking traffic.
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < N; k++) I_s[k*W +: W] = $urandom;
            Sel = 3'($urandom_range(0, 7));
            step();
            check_eq($sformatf("rst_y_c%0d", c), Y, 32'd0);
            check_eq($sformatf("rst_vld_c%0d", c), {31'd0, Out_Valid}, 32'd0);
        end
        rst      = 1'b0;
        In_Valid = 1'b0;
        step();
        check_eq("post_rst_vld", {31'd0, Out_Valid}, 32'd0);

        // Full sweep, then the same stream with a 2-cycle stall mid-stream.
        run_stream(1000, 0, "sweep");
        run_stream(3, 2, "stall");

        // Valid bubbles: In_Valid 1/0 alternating, Sel fixed at 5.
        I_s = '0;
        I_s[5*W +: W] = 32'hDEAD_BEEF;
        Sel = 3'd5;
        En  = 1'b1;
        for (int t = 0; t < N + LAT + 1; t++) begin
            In_Valid = (t < N) ? ((t % 2) == 0) : 1'b0;
            step();
            r = t - (LAT - 1);
            if (r >= 0 && r < N && (r % 2) == 0) begin
                check_eq($sformatf("bub_vld_t%0d", t), {31'd0, Out_Valid}, 32'd1);
                check_eq($sformatf("bub_y_t%0d", t), Y, 32'hDEAD_BEEF);
            end else begin
                check_eq($sformatf("bub_vld_t%0d", t), {31'd0, Out_Valid}, 32'd0);
            end
        end

        // Reset mid-flight, with En=0 during reset to confirm rst wins.
        ramp_inputs();
        En = 1'b1;
        for (int s = 1; s <= 3; s++) begin
            Sel      = 3'(s);
            In_Valid = 1'b1;
            step();
        end
        rst      = 1'b1;
        En       = 1'b0;
        In_Valid = 1'b1;
        Sel      = 3'd7;
        step();
        check_eq("mid_rst_vld", {31'd0, Out_Valid}, 32'd0);
        check_eq("mid_rst_y", Y, 32'd0);
        rst      = 1'b0;
        En       = 1'b1;
        In_Valid = 1'b0;
        for (int c = 0; c < LAT + 2; c++) begin
            step();
            check_eq($sformatf("flush_vld_c%0d", c), {31'd0, Out_Valid}, 32'd0);
        end
        Sel      = 3'd6;
        In_Valid = 1'b1;
        for (int c = 1; c <= LAT + 1; c++) begin
            step();
            In_Valid = 1'b0;
            if (c == LAT) begin
                check_eq($sformatf("new_vld_c%0d", c), {31'd0, Out_Valid}, 32'd1);
                check_eq($sformatf("new_y_c%0d", c), Y, 32'hA000_0006);
            end else begin
                check_eq($sformatf("new_vld_c%0d", c), {31'd0, Out_Valid}, 32'd0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_mux_tree.md
# pipe_mux_tree

Parametrised N-to-1 selector built as a binary tree of 2:1 stages, with optional pipeline registers between tree levels. It generalises the fixed 8:1 data-path selectors to any power-of-two input count, adds a valid flag that travels with the data, and adds a global stall. The multicycle datapath uses it for wide operand and write-back selection, where a combinational 32- or 64-way select would limit the clock period.

## Interface
Parameters:
- WIDTH, 32, data width of each input and of the output
- NUM_INPUTS, 8, number of inputs; power of two, 2..64
- SEL_W, localparam = log2(NUM_INPUTS), select width and tree depth L

Ports:
- clk  input  1  single clock; all registers update on its rising edge
- rst  input  1  reset, synchronous, active-high
- En  input  1  advance enable; 0 = every register holds (stall)
- In_Valid  input  1  marks I/Sel as a valid request this cycle
- I  input  WIDTH*NUM_INPUTS  packed inputs; input k = I[k*WIDTH +: WIDTH]
- Sel  input  SEL_W  index of the input to forward
- Y  output  WIDTH  selected data, registered
- Out_Valid  output  1  Y holds the result of a valid request

## Operation
- Function: Y = input[Sel] as sampled when the request was accepted.
- Tree levels are numbered k = 0..L-1. Level k halves the candidate set using Sel[k].
  - Level 0 pairs inputs (2j, 2j+1) and picks by Sel[0].
  - Each later level pairs adjacent survivors of the previous level.
- Unused select bits Sel[SEL_W-1:k+1] travel with the data through every register stage, so each level uses the Sel value of its own request.
- In_Valid travels with the data through every register stage.
- Every request is accepted, including those with In_Valid=0. There is no back-pressure.
- Stall:
  - With En=0 and rst=0, all data, select and valid registers hold, including Y and Out_Valid.
  - Inputs presented while En=0 are ignored.
- Reset:
  - With rst=1, all data registers (including Y) go to 0 and all valid registers (including Out_Valid) go to 0 on the next edge, regardless of En.
  - Reset mid-operation discards every in-flight request; none reappears after reset is released.
- Y is don't-care-checked only when Out_Valid=1. It still updates when invalid data advances.
- NUM_INPUTS=2 gives a single level. Behaviour is the same with latency 1.

## Timing
- Reset values: Y = 0, Out_Valid = 0.
- Latency, with the macro defined: L cycles of En=1 from acceptance to Y/Out_Valid.
  - Example: N=8 gives 3 cycles; N=64 gives 6 cycles.
- Latency, without the macro: 1 cycle.
- Throughput: one request per cycle while En=1.
- Stalls add exactly one cycle of latency per cycle of En=0. Requests keep their order, with no loss or duplication.
- rst and En together: rst has priority.
- A request accepted on the same edge that rst deasserts is not accepted. The first accepted request is at the first edge with rst=0 and En=1.

## Configuration
- PIPE_MUX_TREE_STAGE_REG_EN defined:
  - A register stage follows every tree level (data, remaining Sel bits, valid).
  - Latency = L.
  - Critical path is one 2:1 mux.
- Undefined:
  - The whole tree is combinational, followed by a single output register for Y and Out_Valid.
  - Latency = 1.
  - Stall and reset rules are unchanged.

## Test plan
- Reset: hold rst=1 for 2 cycles with En=1, In_Valid=1 and random inputs -> Y=0 and Out_Valid=0 during reset and on the first cycle after release.
- Full sweep (N=8, W=32, macro defined): input k = 32'hA000_0000+k, Sel stepping 0..7 on consecutive cycles with In_Valid=1, En=1 -> Y = 32'hA000_0000..32'hA000_0007 in order, starting 3 cycles after the first request, Out_Valid=1 for 8 consecutive cycles.
- Stall: same stream with En=0 for 2 cycles mid-stream -> Y and Out_Valid frozen during the stall, no value skipped or repeated, last result delayed by exactly 2 cycles.
- Valid bubbles: alternate In_Valid 1/0 with Sel=5 and input 5 = 32'hDEAD_BEEF -> Out_Valid toggles 1/0 with the same pattern delayed by L, and Y=32'hDEAD_BEEF whenever Out_Valid=1.
- Reset mid-flight: issue 3 valid requests, then assert rst for 1 cycle -> Out_Valid stays 0 afterwards until a new request has traversed all L stages.
- Macro undefined, N=64, W=8: Sel=63 with input 63 = 8'h5A -> Y=8'h5A and Out_Valid=1 one cycle later.
